// File: rtl/bus_arbiter_2m_if.sv
// Avalon-style single-word bus used on both master-facing ports and the
// shared slave port of bus_arbiter_2m.
interface bus_arbiter_2m_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   addr;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic [1:0]          response;
    logic                waitrequest;

    // Bus initiator: issues the command, receives the return path.
    modport master (
        output addr, read, write, writedata, byteenable,
        input  readdata, response, waitrequest
    );

    // Bus target: accepts the command, drives the return path.
    modport slave (
        input  addr, read, write, writedata, byteenable,
        output readdata, response, waitrequest
    );
endinterface

// File: rtl/bus_arbiter_2m.sv
// Round-robin arbiter giving a CPU (m0) and a DMA (m1) master access to one
// shared slave, one transfer per grant, with an optional slave-stall abort.
module bus_arbiter_2m #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    bus_arbiter_2m_if.slave  m0,
    bus_arbiter_2m_if.slave  m1,
    bus_arbiter_2m_if.master s,
    output logic             timeout_pulse
);
    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e          state_q;
    logic            last_grant_q;
    logic [CntW-1:0] stall_cnt_q;

    logic                own0, own1, owned;
    logic                req0, req1;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_be;
    logic                sel_read, sel_write;
    logic                tmo_hit;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    always_comb begin
        // Outputs are forced idle while rst is high, even before the first edge.
        own0  = ~rst & (state_q == StOwn0);
        own1  = ~rst & (state_q == StOwn1);
        owned = own0 | own1;

        sel_addr  = own1 ? m1.addr       : m0.addr;
        sel_wdata = own1 ? m1.writedata  : m0.writedata;
        sel_be    = own1 ? m1.byteenable : m0.byteenable;
        sel_read  = own1 ? m1.read       : m0.read;
        sel_write = own1 ? m1.write      : m0.write;

        tmo_hit = owned & (TIMEOUT != 0) & s.waitrequest
                & (stall_cnt_q == CntW'(TIMEOUT));

        s.addr       = owned ? sel_addr  : '0;
        s.writedata  = owned ? sel_wdata : '0;
        s.byteenable = owned ? sel_be    : '0;
        s.write      = owned & sel_write & ~tmo_hit;
        s.read       = owned & sel_read & ~sel_write & ~tmo_hit;

        m0.waitrequest = 1'b1;
        m0.readdata    = '0;
        m0.response    = 2'b00;
        m1.waitrequest = 1'b1;
        m1.readdata    = '0;
        m1.response    = 2'b00;

        if (own0) begin
            m0.waitrequest = s.waitrequest & ~tmo_hit;
            m0.readdata    = tmo_hit ? '0 : s.readdata;
            m0.response    = tmo_hit ? RespSlvErr : s.response;
        end
        if (own1) begin
            m1.waitrequest = s.waitrequest & ~tmo_hit;
            m1.readdata    = tmo_hit ? '0 : s.readdata;
            m1.response    = tmo_hit ? RespSlvErr : s.response;
        end

        timeout_pulse = tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    stall_cnt_q <= '0;
                    // On contention the master that did not go last wins.
                    if (req0 && (!req1 || last_grant_q)) begin
                        state_q <= StOwn0;
                    end else if (req1) begin
                        state_q <= StOwn1;
                    end
                end
                StOwn0, StOwn1: begin
                    if (!(sel_read || sel_write) || !s.waitrequest || tmo_hit) begin
                        state_q      <= StIdle;
                        last_grant_q <= (state_q == StOwn1);
                    end else begin
                        stall_cnt_q <= stall_cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Scoreboard bench for bus_arbiter_2m: expected completions are queued with
// the cycle they must occur in and popped when a master sees waitrequest low.
module tb_bus_arbiter_2m;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;

    typedef struct {
        int          m;
        int          cyc;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic tpulse;

    logic        slv_wait;
    logic [1:0]  slv_resp;
    logic        use_fixed;
    logic [31:0] fixed_data;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    bus_arbiter_2m_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
    bus_arbiter_2m_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
    bus_arbiter_2m_if #(.ADDR_W(AW), .DATA_W(DW)) s_bus ();

    bus_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .m0            (m0_bus),
        .m1            (m1_bus),
        .s             (s_bus),
        .timeout_pulse (tpulse)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign s_bus.readdata    = use_fixed ? fixed_data : slv_data(s_bus.addr);
    assign s_bus.response    = slv_resp;
    assign s_bus.waitrequest = slv_wait;

    function automatic bit done_of(input int m);
        if (m == 0) return (m0_bus.read | m0_bus.write) & ~m0_bus.waitrequest;
        return (m1_bus.read | m1_bus.write) & ~m1_bus.waitrequest;
    endfunction

    function automatic logic [31:0] rdata_of(input int m);
        return (m == 0) ? m0_bus.readdata : m1_bus.readdata;
    endfunction

    function automatic logic [1:0] resp_of(input int m);
        return (m == 0) ? m0_bus.response : m1_bus.response;
    endfunction

    task automatic push_exp(input int m, input int cyc, input logic [31:0] d,
                            input logic [1:0] r);
        exp_t e;
        e.m = m; e.cyc = cyc; e.data = d; e.resp = r;
        sb.push_back(e);
    endtask

    task automatic clear_masters();
        m0_bus.addr = '0; m0_bus.read = 0; m0_bus.write = 0;
        m0_bus.writedata = '0; m0_bus.byteenable = '0;
        m1_bus.addr = '0; m1_bus.read = 0; m1_bus.write = 0;
        m1_bus.writedata = '0; m1_bus.byteenable = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_bus.read = 1'b1; m0_bus.addr = 32'h40;
        m1_bus.write = 1'b1; m1_bus.addr = 32'h80;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (s_bus.read !== 1'b0 || s_bus.write !== 1'b0 || m0_bus.waitrequest !== 1'b1 ||
                m1_bus.waitrequest !== 1'b1 || tpulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: s_read=%b s_write=%b m0_wait=%b m1_wait=%b tp=%b, required 0 0 1 1 0",
                         s_bus.read, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest, tpulse);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_masters();
        @(negedge clk);
        checks++;
        if (s_bus.read !== 1'b0 || s_bus.write !== 1'b0 || m0_bus.waitrequest !== 1'b1 ||
            m1_bus.waitrequest !== 1'b1 || tpulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle: s_read=%b s_write=%b m0_wait=%b m1_wait=%b tp=%b, required 0 0 1 1 0",
                     s_bus.read, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest, tpulse);
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        int   gm;
        @(posedge clk); #1;
        m0_bus.addr = 32'h100; m0_bus.read = 1'b1;
        use_fixed = 1'b1; fixed_data = 32'hDEADBEEF; slv_wait = 1'b0; slv_resp = 2'b00;
        push_exp(0, 1, 32'hDEADBEEF, 2'b00);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 2) m0_bus.read = 1'b0;
            @(negedge clk);
            checks++;
            if (s_bus.read !== (c == 1) || m0_bus.waitrequest !== (c != 1)) begin
                errors++;
                $display("FAIL single_cmd: cycle %0d s_read=%b m0_wait=%b, required %b %b",
                         c, s_bus.read, m0_bus.waitrequest, (c == 1), (c != 1));
            end
            if (c == 1) begin
                checks++;
                if (s_bus.addr !== 32'h100) begin
                    errors++;
                    $display("FAIL single_addr: s_addr=%h, required 00000100", s_bus.addr);
                end
            end
            if (done_of(0) || done_of(1)) begin
                gm = done_of(1) ? 1 : 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL single_unexpected: m%0d completed in cycle %0d, required none", gm, c);
                end else begin
                    e = sb.pop_front();
                    if (gm != e.m || c != e.cyc || rdata_of(gm) !== e.data || resp_of(gm) !== e.resp) begin
                        errors++;
                        $display("FAIL single_done: got m%0d cyc %0d data %h resp %b, required m%0d cyc %0d data %h resp %b",
                                 gm, c, rdata_of(gm), resp_of(gm), e.m, e.cyc, e.data, e.resp);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_leftover: %0d completions missing, required 0", sb.size());
            sb.delete();
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   gm;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m0_bus.addr = 32'h200; m0_bus.read = 1'b1;
        m1_bus.addr = 32'h300; m1_bus.read = 1'b1;
        slv_wait = 1'b0;
        push_exp(0, 1, slv_data(32'h200), 2'b00);
        push_exp(1, 3, slv_data(32'h300), 2'b00);
        push_exp(0, 5, slv_data(32'h200), 2'b00);
        push_exp(1, 7, slv_data(32'h300), 2'b00);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            checks++;
            if (s_bus.read !== (c % 2 == 1)) begin
                errors++;
                $display("FAIL rr_cmd: cycle %0d s_read=%b, required %b", c, s_bus.read, (c % 2 == 1));
            end
            if (done_of(0)) begin
                checks++;
                if (m1_bus.waitrequest !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_m1_wait: cycle %0d m1_wait=%b, required 1", c, m1_bus.waitrequest);
                end
            end
            if (done_of(0) || done_of(1)) begin
                gm = done_of(1) ? 1 : 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rr_unexpected: m%0d completed in cycle %0d, required none", gm, c);
                end else begin
                    e = sb.pop_front();
                    if (gm != e.m || c != e.cyc || rdata_of(gm) !== e.data || resp_of(gm) !== e.resp) begin
                        errors++;
                        $display("FAIL rr_done: got m%0d cyc %0d data %h resp %b, required m%0d cyc %0d data %h resp %b",
                                 gm, c, rdata_of(gm), resp_of(gm), e.m, e.cyc, e.data, e.resp);
                    end
                end
            end
        end
        @(posedge clk); #1;
        clear_masters();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rr_leftover: %0d completions missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_stalled_write();
        exp_t e;
        int   gm;
        m1_bus.addr = 32'h400; m1_bus.write = 1'b1;
        m1_bus.writedata = 32'h12345678; m1_bus.byteenable = 4'h3;
        slv_wait = 1'b1;
        push_exp(1, 4, slv_data(32'h400), 2'b00);
        push_exp(0, 6, slv_data(32'h500), 2'b00);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 2) begin m0_bus.addr = 32'h500; m0_bus.read = 1'b1; end
            if (c == 4) slv_wait = 1'b0;
            if (c == 5) m1_bus.write = 1'b0;
            if (c == 7) m0_bus.read = 1'b0;
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                checks++;
                if (s_bus.write !== 1'b1 || s_bus.read !== 1'b0 || s_bus.addr !== 32'h400 ||
                    s_bus.writedata !== 32'h12345678 || s_bus.byteenable !== 4'h3 || tpulse !== 1'b0) begin
                    errors++;
                    $display("FAIL sw_cmd: cycle %0d wr=%b rd=%b addr=%h wd=%h be=%h tp=%b, required 1 0 00000400 12345678 3 0",
                             c, s_bus.write, s_bus.read, s_bus.addr, s_bus.writedata, s_bus.byteenable, tpulse);
                end
            end
            if (c <= 5) begin
                checks++;
                if (m0_bus.waitrequest !== 1'b1) begin
                    errors++;
                    $display("FAIL sw_m0_wait: cycle %0d m0_wait=%b, required 1", c, m0_bus.waitrequest);
                end
            end
            if (done_of(0) || done_of(1)) begin
                gm = done_of(1) ? 1 : 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sw_unexpected: m%0d completed in cycle %0d, required none", gm, c);
                end else begin
                    e = sb.pop_front();
                    if (gm != e.m || c != e.cyc || rdata_of(gm) !== e.data || resp_of(gm) !== e.resp) begin
                        errors++;
                        $display("FAIL sw_done: got m%0d cyc %0d data %h resp %b, required m%0d cyc %0d data %h resp %b",
                                 gm, c, rdata_of(gm), resp_of(gm), e.m, e.cyc, e.data, e.resp);
                    end
                end
            end
        end
        clear_masters();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sw_leftover: %0d completions missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   gm;
        @(posedge clk); #1;
        m0_bus.addr = 32'h600; m0_bus.read = 1'b1;
        slv_wait = 1'b1;
        push_exp(0, 5, 32'h0, 2'b10);
        push_exp(1, 7, slv_data(32'h700), 2'b00);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 2) begin
                m1_bus.addr = 32'h700; m1_bus.write = 1'b1;
                m1_bus.writedata = 32'hCAFEF00D; m1_bus.byteenable = 4'hF;
            end
            if (c == 6) begin m0_bus.read = 1'b0; slv_wait = 1'b0; end
            if (c == 8) m1_bus.write = 1'b0;
            @(negedge clk);
            checks++;
            if (tpulse !== (c == 5)) begin
                errors++;
                $display("FAIL to_pulse: cycle %0d tp=%b, required %b", c, tpulse, (c == 5));
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (s_bus.read !== 1'b1 || m0_bus.waitrequest !== 1'b1 || m1_bus.waitrequest !== 1'b1) begin
                    errors++;
                    $display("FAIL to_stall: cycle %0d s_read=%b m0_wait=%b m1_wait=%b, required 1 1 1",
                             c, s_bus.read, m0_bus.waitrequest, m1_bus.waitrequest);
                end
            end
            if (c == 5) begin
                checks++;
                if (s_bus.read !== 1'b0 || s_bus.write !== 1'b0) begin
                    errors++;
                    $display("FAIL to_abort_cmd: s_read=%b s_write=%b, required 0 0", s_bus.read, s_bus.write);
                end
            end
            if (done_of(0) || done_of(1)) begin
                gm = done_of(1) ? 1 : 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL to_unexpected: m%0d completed in cycle %0d, required none", gm, c);
                end else begin
                    e = sb.pop_front();
                    if (gm != e.m || c != e.cyc || rdata_of(gm) !== e.data || resp_of(gm) !== e.resp) begin
                        errors++;
                        $display("FAIL to_done: got m%0d cyc %0d data %h resp %b, required m%0d cyc %0d data %h resp %b",
                                 gm, c, rdata_of(gm), resp_of(gm), e.m, e.cyc, e.data, e.resp);
                    end
                end
            end
        end
        clear_masters();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL to_leftover: %0d completions missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_error_response();
        exp_t e;
        int   gm;
        @(posedge clk); #1;
        m0_bus.addr = 32'h640; m0_bus.read = 1'b1; m0_bus.write = 1'b1;
        m0_bus.writedata = 32'hA5A5A5A5; m0_bus.byteenable = 4'hF;
        slv_resp = 2'b10; slv_wait = 1'b0;
        push_exp(0, 1, slv_data(32'h640), 2'b10);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 2) begin clear_masters(); slv_resp = 2'b00; end
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (s_bus.write !== 1'b1 || s_bus.read !== 1'b0) begin
                    errors++;
                    $display("FAIL ew_write_wins: s_write=%b s_read=%b, required 1 0", s_bus.write, s_bus.read);
                end
            end
            if (done_of(0) || done_of(1)) begin
                gm = done_of(1) ? 1 : 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL ew_unexpected: m%0d completed in cycle %0d, required none", gm, c);
                end else begin
                    e = sb.pop_front();
                    if (gm != e.m || c != e.cyc || rdata_of(gm) !== e.data || resp_of(gm) !== e.resp) begin
                        errors++;
                        $display("FAIL ew_done: got m%0d cyc %0d data %h resp %b, required m%0d cyc %0d data %h resp %b",
                                 gm, c, rdata_of(gm), resp_of(gm), e.m, e.cyc, e.data, e.resp);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL ew_leftover: %0d completions missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   gm;
        @(posedge clk); #1;
        m1_bus.addr = 32'h800; m1_bus.write = 1'b1;
        m1_bus.writedata = 32'h11112222; m1_bus.byteenable = 4'hF;
        slv_wait = 1'b1;
        push_exp(0, 5, slv_data(32'h900), 2'b00);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 3) rst = 1'b1;
            if (c == 4) begin
                rst = 1'b0;
                m0_bus.addr = 32'h900; m0_bus.read = 1'b1;
                slv_wait = 1'b0;
            end
            if (c == 6) clear_masters();
            @(negedge clk);
            checks++;
            if (tpulse !== 1'b0) begin
                errors++;
                $display("FAIL rm_pulse: cycle %0d tp=%b, required 0", c, tpulse);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (s_bus.write !== 1'b1) begin
                    errors++;
                    $display("FAIL rm_own1: cycle %0d s_write=%b, required 1", c, s_bus.write);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (s_bus.write !== 1'b0 || s_bus.read !== 1'b0 ||
                    m0_bus.waitrequest !== 1'b1 || m1_bus.waitrequest !== 1'b1) begin
                    errors++;
                    $display("FAIL rm_idle: cycle %0d s_write=%b s_read=%b m0_wait=%b m1_wait=%b, required 0 0 1 1",
                             c, s_bus.write, s_bus.read, m0_bus.waitrequest, m1_bus.waitrequest);
                end
            end
            if (c == 5) begin
                checks++;
                if (s_bus.read !== 1'b1 || s_bus.addr !== 32'h900 || m1_bus.waitrequest !== 1'b1) begin
                    errors++;
                    $display("FAIL rm_grant: s_read=%b s_addr=%h m1_wait=%b, required 1 00000900 1",
                             s_bus.read, s_bus.addr, m1_bus.waitrequest);
                end
            end
            if (done_of(0) || done_of(1)) begin
                gm = done_of(1) ? 1 : 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rm_unexpected: m%0d completed in cycle %0d, required none", gm, c);
                end else begin
                    e = sb.pop_front();
                    if (gm != e.m || c != e.cyc || rdata_of(gm) !== e.data || resp_of(gm) !== e.resp) begin
                        errors++;
                        $display("FAIL rm_done: got m%0d cyc %0d data %h resp %b, required m%0d cyc %0d data %h resp %b",
                                 gm, c, rdata_of(gm), resp_of(gm), e.m, e.cyc, e.data, e.resp);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rm_leftover: %0d completions missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_masters();
        slv_wait = 1'b0;
        slv_resp = 2'b00;
        use_fixed = 1'b0;
        fixed_data = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_stalled_write();
        test_timeout();
        test_error_response();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
